// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer: state encoding and the
// 34-bit core instruction field map.
package core_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_W_L0   = 4'd1,
      ST_W_LOAD = 4'd2,
      ST_GAP    = 4'd3,
      ST_X_L0   = 4'd4,
      ST_EXEC   = 4'd5,
      ST_DRAIN  = 4'd6,
      ST_OFIFO  = 4'd7,
      ST_NEXT   = 4'd8,
      ST_DONE   = 4'd9
   } seq_state_e;

   localparam int INST_ACC       = 33;
   localparam int INST_CEN_PMEM  = 32;
   localparam int INST_WEN_PMEM  = 31;
   localparam int INST_A_PMEM_HI = 30;
   localparam int INST_A_PMEM_LO = 20;
   localparam int INST_CEN_XMEM  = 19;
   localparam int INST_WEN_XMEM  = 18;
   localparam int INST_A_XMEM_HI = 17;
   localparam int INST_A_XMEM_LO = 7;
   localparam int INST_OFIFO_RD  = 6;
   localparam int INST_IFIFO_WR  = 5;
   localparam int INST_IFIFO_RD  = 4;
   localparam int INST_L0_RD     = 3;
   localparam int INST_L0_WR     = 2;
   localparam int INST_EXECUTE   = 1;
   localparam int INST_LOAD      = 0;

   // Both memories disabled (chip enable and write enable are active-low).
   localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

endpackage

// File: rtl/core_seq_inst_enc.sv
// Combinational packer of individual core control fields into the inst word.
module core_seq_inst_enc
   import core_pkg::*;
(
   input  logic        acc,
   input  logic        cen_pmem,
   input  logic        wen_pmem,
   input  logic [10:0] a_pmem,
   input  logic        cen_xmem,
   input  logic        wen_xmem,
   input  logic [10:0] a_xmem,
   input  logic        ofifo_rd,
   input  logic        ififo_wr,
   input  logic        ififo_rd,
   input  logic        l0_rd,
   input  logic        l0_wr,
   input  logic        execute,
   input  logic        load,
   output logic [33:0] inst
);

   // Place each field at its fixed bit position.
   always_comb begin
      inst                                = INST_IDLE;
      inst[INST_ACC]                      = acc;
      inst[INST_CEN_PMEM]                 = cen_pmem;
      inst[INST_WEN_PMEM]                 = wen_pmem;
      inst[INST_A_PMEM_HI:INST_A_PMEM_LO] = a_pmem;
      inst[INST_CEN_XMEM]                 = cen_xmem;
      inst[INST_WEN_XMEM]                 = wen_xmem;
      inst[INST_A_XMEM_HI:INST_A_XMEM_LO] = a_xmem;
      inst[INST_OFIFO_RD]                 = ofifo_rd;
      inst[INST_IFIFO_WR]                 = ififo_wr;
      inst[INST_IFIFO_RD]                 = ififo_rd;
      inst[INST_L0_RD]                    = l0_rd;
      inst[INST_L0_WR]                    = l0_wr;
      inst[INST_EXECUTE]                  = execute;
      inst[INST_LOAD]                     = load;
   end

endmodule

// File: rtl/core_seq_ctrl.sv
// Sequencer driving core's inst word through load/execute/writeback per kernel index.
// Optional CORE_SEQ_CTRL_PERF_EN adds saturating busy-cycle and OFIFO-stall counters.
module core_seq_ctrl
   import core_pkg::*;
#(
   parameter int bw      = 4,
   parameter int col     = 8,
   parameter int row     = 8,
   parameter int len_nij = 36,
   parameter int len_kij = 9,
   parameter int gap     = 10,
   parameter int w_base  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        xw_mode,
   output logic        busy,
   output logic        done,
   output logic [3:0]  kij_idx
`ifdef CORE_SEQ_CTRL_PERF_EN
   ,
   output logic [15:0] perf_cycles,
   output logic [15:0] perf_stalls
`endif
);

   localparam logic [7:0] T_W_LAST     = 8'(col - 1);
   localparam logic [7:0] T_GAP_LAST   = 8'(gap - 1);
   localparam logic [7:0] T_NIJ_LAST   = 8'(len_nij - 1);
   localparam logic [7:0] T_DRAIN_LAST = 8'(col + row - 1);
   localparam logic [3:0] KIJ_LAST     = 4'(len_kij - 1);

   if (bw < 1 || len_kij < 1) begin : g_param_check
      $error("core_seq_ctrl: bw and len_kij must be at least 1");
   end

   seq_state_e  st_r, st_nxt_s;
   logic [7:0]  t_r, t_nxt_s;
   logic [3:0]  kij_r, kij_nxt_s;
   logic [33:0] inst_r, inst_nxt_s;
   logic        xw_r, xw_nxt_s;
   logic        busy_r, done_r;
   logic        busy_nxt_s;

   logic        cen_p_s, wen_p_s, cen_x_s;
   logic [10:0] a_p_s, a_x_s;
   logic        ofifo_rd_s, l0_rd_s, l0_wr_s, exe_s, load_s;

   // Next-state, phase counter and kernel index.
   always_comb begin
      st_nxt_s  = st_r;
      t_nxt_s   = t_r;
      kij_nxt_s = kij_r;
      case (st_r)
         ST_IDLE: begin
            if (start) begin
               st_nxt_s  = ST_W_L0;
               t_nxt_s   = 8'd0;
               kij_nxt_s = 4'd0;
            end else begin
               st_nxt_s = ST_IDLE;
            end
         end
         ST_W_L0: begin
            if (t_r == T_W_LAST) begin
               st_nxt_s = ST_W_LOAD;
               t_nxt_s  = 8'd0;
            end else begin
               t_nxt_s = t_r + 8'd1;
            end
         end
         ST_W_LOAD: begin
            if (t_r == T_W_LAST) begin
               st_nxt_s = ST_GAP;
               t_nxt_s  = 8'd0;
            end else begin
               t_nxt_s = t_r + 8'd1;
            end
         end
         ST_GAP: begin
            if (t_r == T_GAP_LAST) begin
               st_nxt_s = ST_X_L0;
               t_nxt_s  = 8'd0;
            end else begin
               t_nxt_s = t_r + 8'd1;
            end
         end
         ST_X_L0: begin
            if (t_r == T_NIJ_LAST) begin
               st_nxt_s = ST_EXEC;
               t_nxt_s  = 8'd0;
            end else begin
               t_nxt_s = t_r + 8'd1;
            end
         end
         ST_EXEC: begin
            if (t_r == T_NIJ_LAST) begin
               st_nxt_s = ST_DRAIN;
               t_nxt_s  = 8'd0;
            end else begin
               t_nxt_s = t_r + 8'd1;
            end
         end
         ST_DRAIN: begin
            if (t_r == T_DRAIN_LAST) begin
               st_nxt_s = ST_OFIFO;
               t_nxt_s  = 8'd0;
            end else begin
               t_nxt_s = t_r + 8'd1;
            end
         end
         ST_OFIFO: begin
            // Only accepted reads advance the writeback address.
            if (ofifo_valid) begin
               if (t_r == T_NIJ_LAST) begin
                  st_nxt_s = ST_NEXT;
                  t_nxt_s  = 8'd0;
               end else begin
                  t_nxt_s = t_r + 8'd1;
               end
            end else begin
               t_nxt_s = t_r;
            end
         end
         ST_NEXT: begin
            t_nxt_s = 8'd0;
            if (kij_r == KIJ_LAST) begin
               st_nxt_s = ST_DONE;
            end else begin
               st_nxt_s  = ST_W_L0;
               kij_nxt_s = kij_r + 4'd1;
            end
         end
         ST_DONE: begin
            st_nxt_s  = ST_IDLE;
            t_nxt_s   = 8'd0;
            kij_nxt_s = 4'd0;
         end
         default: begin
            st_nxt_s  = ST_IDLE;
            t_nxt_s   = 8'd0;
            kij_nxt_s = 4'd0;
         end
      endcase
   end

   // Instruction fields for the upcoming state, so the registered word lines up with it.
   always_comb begin
      cen_p_s    = 1'b1;
      wen_p_s    = 1'b1;
      a_p_s      = 11'd0;
      cen_x_s    = 1'b1;
      a_x_s      = 11'd0;
      ofifo_rd_s = 1'b0;
      l0_rd_s    = 1'b0;
      l0_wr_s    = 1'b0;
      exe_s      = 1'b0;
      load_s     = 1'b0;
      xw_nxt_s   = 1'b0;
      case (st_nxt_s)
         ST_W_L0: begin
            xw_nxt_s = 1'b1;
            cen_x_s  = 1'b0;
            a_x_s    = 11'(w_base + 32'(kij_nxt_s) * col + 32'(t_nxt_s));
            l0_wr_s  = 1'b1;
         end
         ST_W_LOAD: begin
            l0_rd_s = 1'b1;
            load_s  = 1'b1;
         end
         ST_X_L0: begin
            cen_x_s = 1'b0;
            a_x_s   = 11'(t_nxt_s);
            l0_wr_s = 1'b1;
         end
         ST_EXEC: begin
            exe_s   = 1'b1;
            l0_rd_s = 1'b1;
         end
         ST_OFIFO: begin
            ofifo_rd_s = 1'b1;
            cen_p_s    = 1'b0;
            wen_p_s    = 1'b0;
            a_p_s      = 11'(32'(kij_nxt_s) * len_nij + 32'(t_nxt_s));
         end
         default: begin
            xw_nxt_s = 1'b0;
         end
      endcase
   end

   assign busy_nxt_s = (st_nxt_s != ST_IDLE);

   core_seq_inst_enc u_enc (
      .acc      (1'b0),
      .cen_pmem (cen_p_s),
      .wen_pmem (wen_p_s),
      .a_pmem   (a_p_s),
      .cen_xmem (cen_x_s),
      .wen_xmem (1'b1),
      .a_xmem   (a_x_s),
      .ofifo_rd (ofifo_rd_s),
      .ififo_wr (1'b0),
      .ififo_rd (1'b0),
      .l0_rd    (l0_rd_s),
      .l0_wr    (l0_wr_s),
      .execute  (exe_s),
      .load     (load_s),
      .inst     (inst_nxt_s)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_r   <= ST_IDLE;
         t_r    <= 8'd0;
         kij_r  <= 4'd0;
         inst_r <= INST_IDLE;
         xw_r   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         st_r   <= st_nxt_s;
         t_r    <= t_nxt_s;
         kij_r  <= kij_nxt_s;
         inst_r <= inst_nxt_s;
         xw_r   <= xw_nxt_s;
         busy_r <= busy_nxt_s;
         done_r <= (st_nxt_s == ST_DONE);
      end
   end

   // A writeback slot without valid data must not read the OFIFO or write pmem.
   assign inst    = (st_r == ST_OFIFO && !ofifo_valid) ? INST_IDLE : inst_r;
   assign xw_mode = xw_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign kij_idx = kij_r;

`ifdef CORE_SEQ_CTRL_PERF_EN
   logic [15:0] perf_cycles_r, perf_stalls_r;

   // Saturating counters; the start cycle opens the count with the first busy cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_cycles_r <= 16'd0;
         perf_stalls_r <= 16'd0;
      end else if (st_r == ST_IDLE && start) begin
         perf_cycles_r <= 16'd1;
         perf_stalls_r <= 16'd0;
      end else begin
         if (busy_nxt_s && perf_cycles_r != 16'hFFFF) begin
            perf_cycles_r <= perf_cycles_r + 16'd1;
         end else begin
            perf_cycles_r <= perf_cycles_r;
         end
         if (st_r == ST_OFIFO && !ofifo_valid && perf_stalls_r != 16'hFFFF) begin
            perf_stalls_r <= perf_stalls_r + 16'd1;
         end else begin
            perf_stalls_r <= perf_stalls_r;
         end
      end
   end

   assign perf_cycles = perf_cycles_r;
   assign perf_stalls = perf_stalls_r;
`endif

endmodule
